// File: rtl/nvram_pkg.sv
// nvram_pkg: shared state encoding and constants for the NVRAM port-B controller.
package nvram_pkg;

    localparam int unsigned NV_AW        = 9;
    localparam int unsigned NV_DEPTH     = 512;
    localparam logic [7:0]  NV_FILL_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DL,
        ST_UL_ADDR,
        ST_UL_DATA,
        ST_WIPE
    } nv_state_t;

endpackage

// File: rtl/nvram_port_ctrl_quiet_timer.sv
// nvram_quiet_timer: counts idle cycles while the image is dirty and raises one save request.
// Built into nvram_port_ctrl only when NVRAM_AUTOSAVE_EN is defined.
module nvram_quiet_timer #(
    parameter logic [23:0] QUIET_CYCLES = 24'd2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic save_req
);

    logic [23:0] cnt;

    // The counter parks at QUIET_CYCLES so the request fires once per quiet period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            save_req <= 1'b0;
        end else begin
            save_req <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (count_en && cnt != QUIET_CYCLES) begin
                cnt      <= cnt + 24'd1;
                save_req <= (cnt + 24'd1 == QUIET_CYCLES);
            end
        end
    end

endmodule

// File: rtl/nvram_port_ctrl.sv
// nvram_port_ctrl: owns NVRAM port B - ioctl load/save, 0xFF wipe and dirty tracking.
// Define NVRAM_AUTOSAVE_EN to build the quiet-time autosave request on save_req.
module nvram_port_ctrl
    import nvram_pkg::*;
#(
    parameter int unsigned AW           = NV_AW,
    parameter int unsigned DEPTH        = NV_DEPTH,
    parameter logic [7:0]  NV_INDEX     = 8'd4,
    parameter logic [23:0] QUIET_CYCLES = 24'd2_000_000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_din_valid,
    input  logic          wipe,
    input  logic          cpu_nv_we,
    output logic [AW-1:0] nv_addr,
    output logic          nv_we,
    output logic [7:0]    nv_din,
    input  logic [7:0]    nv_dout,
    output logic          busy,
    output logic          nv_dirty,
    output logic          save_req
);

    localparam logic [24:0]   DEPTH_A   = 25'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Handshake: ioctl_wr/ioctl_rd are single-cycle strobes with no ready; ioctl_din
    // is meaningful only in the cycle ioctl_din_valid is high.
    nv_state_t     state, state_n;
    logic          wipe_pend, wipe_pend_n;
    logic [AW-1:0] addr_n;
    logic          we_n;
    logic [7:0]    din_n;
    logic          ul_oor, ul_oor_n;
    logic          ul_done, ul_sel_q;
    logic [7:0]    din_hold, rd_byte;
    logic          selected, dl_sel, ul_sel, in_range;
    logic          dl_clr, ul_fall, ul_clr, wipe_done, dirty_n;

    assign selected = (ioctl_index == NV_INDEX);
    assign dl_sel   = ioctl_download && selected;
    assign ul_sel   = ioctl_upload && selected;
    assign in_range = (ioctl_addr < DEPTH_A);
    assign ul_fall  = ul_sel_q && !ioctl_upload;
    assign ul_clr   = ul_fall && (ul_done || state == ST_UL_DATA);

    always_comb begin
        state_n     = state;
        wipe_pend_n = wipe_pend;
        addr_n      = nv_addr;
        we_n        = 1'b0;
        din_n       = nv_din;
        ul_oor_n    = ul_oor;
        dl_clr      = 1'b0;
        wipe_done   = 1'b0;
        if (wipe && state != ST_IDLE) wipe_pend_n = 1'b1;
        case (state)
            ST_IDLE: begin
                if (wipe || wipe_pend) begin
                    state_n     = ST_WIPE;
                    wipe_pend_n = 1'b0;
                    addr_n      = '0;
                    we_n        = 1'b1;
                    din_n       = NV_FILL_BYTE;
                end else if (dl_sel) begin
                    state_n = ST_DL;
                end else if (ul_sel && ioctl_rd) begin
                    state_n  = ST_UL_ADDR;
                    ul_oor_n = !in_range;
                    // Out-of-range reads leave the RAM address untouched.
                    if (in_range) addr_n = ioctl_addr[AW-1:0];
                end
            end
            ST_DL: begin
                if (!ioctl_download) begin
                    state_n = ST_IDLE;
                    dl_clr  = 1'b1;
                end else if (ioctl_wr && in_range) begin
                    we_n   = 1'b1;
                    addr_n = ioctl_addr[AW-1:0];
                    din_n  = ioctl_dout;
                end
            end
            ST_UL_ADDR: state_n = ST_UL_DATA;
            ST_UL_DATA: state_n = ST_IDLE;
            ST_WIPE: begin
                if (nv_addr == LAST_ADDR) begin
                    state_n   = ST_IDLE;
                    wipe_done = 1'b1;
                end else begin
                    addr_n = nv_addr + AW'(1);
                    we_n   = 1'b1;
                    din_n  = NV_FILL_BYTE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // A CPU write in the same cycle as a load/save clear keeps the image dirty.
    assign dirty_n = (nv_dirty && !(dl_clr || ul_clr)) || wipe_done || cpu_nv_we;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= ST_IDLE;
            wipe_pend <= 1'b0;
            nv_addr   <= '0;
            nv_we     <= 1'b0;
            nv_din    <= '0;
            busy      <= 1'b0;
            nv_dirty  <= 1'b0;
            ul_oor    <= 1'b0;
            ul_done   <= 1'b0;
            ul_sel_q  <= 1'b0;
            din_hold  <= '0;
        end else begin
            state     <= state_n;
            wipe_pend <= wipe_pend_n;
            nv_addr   <= addr_n;
            nv_we     <= we_n;
            nv_din    <= din_n;
            busy      <= (state_n != ST_IDLE);
            nv_dirty  <= dirty_n;
            ul_oor    <= ul_oor_n;
            ul_sel_q  <= ul_sel;
            if (ul_fall)                    ul_done <= 1'b0;
            else if (state == ST_UL_DATA)   ul_done <= 1'b1;
            if (state == ST_UL_DATA)        din_hold <= rd_byte;
        end
    end

    // The RAM read lands in UL_DATA, so the byte is forwarded straight from nv_dout.
    assign rd_byte         = ul_oor ? NV_FILL_BYTE : nv_dout;
    assign ioctl_din_valid = (state == ST_UL_DATA);
    assign ioctl_din       = ioctl_din_valid ? rd_byte : din_hold;

`ifdef NVRAM_AUTOSAVE_EN
    nvram_quiet_timer #(
        .QUIET_CYCLES(QUIET_CYCLES)
    ) u_quiet_timer (
        .clk      (clk_sys),
        .reset    (reset),
        .clear    (cpu_nv_we || ul_clr),
        .count_en (nv_dirty && state == ST_IDLE),
        .save_req (save_req)
    );
`else
    logic unused_quiet;
    assign unused_quiet = ^QUIET_CYCLES;
    assign save_req     = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_port_ctrl.sv
// tb_nvram_port_ctrl: directed scoreboard bench for nvram_port_ctrl with a port-B RAM model.
module tb_nvram_port_ctrl;

    localparam int         W  = 49;
    localparam logic [7:0] NV = 8'd4;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0, ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0, ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_din_valid;
    logic        wipe = 1'b0, cpu_nv_we = 1'b0;
    logic [8:0]  nv_addr;
    logic        nv_we;
    logic [7:0]  nv_din;
    logic [7:0]  nv_dout = '0;
    logic        busy, nv_dirty, save_req;

    logic [7:0]  mem [0:511];
    logic [31:0] cyc = '0;
    logic [W-1:0] wr_q[$];
    logic [W-1:0] rd_q[$];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 32'd1;

    always @(posedge clk_sys) begin
        if (nv_we) mem[nv_addr] <= nv_din;
        nv_dout <= mem[nv_addr];
    end

    nvram_port_ctrl #(.QUIET_CYCLES(24'd16)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .ioctl_din_valid(ioctl_din_valid),
        .wipe(wipe), .cpu_nv_we(cpu_nv_we),
        .nv_addr(nv_addr), .nv_we(nv_we), .nv_din(nv_din), .nv_dout(nv_dout),
        .busy(busy), .nv_dirty(nv_dirty), .save_req(save_req)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name, input logic [W-1:0] act);
        n_total++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic read_byte(input logic [24:0] a, input logic [7:0] exp);
        ioctl_rd = 1'b1;
        ioctl_addr = a;
        rd_q.push_back({cyc + 32'd2, 9'd0, exp});
        tick();
        ioctl_rd = 1'b0;
        tick();
        tick();
    endtask

    // Monitors: every port-B write and every upload byte is matched against the queues.
    always @(negedge clk_sys) begin
        if (nv_we) begin
            if (wr_q.size() == 0) note_fail("unexpected_write", {cyc, nv_addr, nv_din});
            else check("nv_write", {cyc, nv_addr, nv_din}, wr_q.pop_front());
        end
        if (ioctl_din_valid) begin
            if (rd_q.size() == 0) note_fail("unexpected_read", {cyc, 9'd0, ioctl_din});
            else check("ioctl_read", {cyc, 9'd0, ioctl_din}, rd_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", n_total);
        $fatal(1);
    end

    initial begin
        logic [31:0] c, at;
        logic [7:0]  d8;
        int n, errs;

        repeat (3) tick();
        check("reset_outputs", W'({nv_addr, nv_we, nv_din, ioctl_din, ioctl_din_valid,
                                   busy, nv_dirty, save_req}), W'(0));
        reset = 1'b0;
        tick();

        // Full 512-byte download, one strobe per cycle.
        ioctl_index = NV;
        ioctl_download = 1'b1;
        tick();
        cpu_nv_we = 1'b1;
        tick();
        cpu_nv_we = 1'b0;
        tick();
        check("dirty_cpu_set", W'(nv_dirty), W'(1));
        for (int i = 0; i < 512; i++) begin
            d8 = 8'(i) ^ 8'h5A;
            ioctl_wr = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = d8;
            wr_q.push_back({cyc + 32'd1, 9'(i), d8});
            tick();
        end
        ioctl_addr = 25'h1FF;
        ioctl_dout = 8'hA7;
        wr_q.push_back({cyc + 32'd1, 9'h1FF, 8'hA7});
        tick();
        ioctl_addr = 25'd600;
        ioctl_dout = 8'h33;
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
        check("dirty_dl_clear", W'({busy, nv_dirty}), W'(0));
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            d8 = (i == 511) ? 8'hA7 : (8'(i) ^ 8'h5A);
            if (mem[i] !== d8) errs++;
        end
        check("ram_image", W'(errs), W'(0));

        // Upload: address phase, dropped second strobe, out-of-range and normal reads.
        cpu_nv_we = 1'b1;
        tick();
        cpu_nv_we = 1'b0;
        ioctl_upload = 1'b1;
        tick();
        check("dirty_before_ul", W'(nv_dirty), W'(1));
        ioctl_rd = 1'b1;
        ioctl_addr = 25'h1FF;
        rd_q.push_back({cyc + 32'd2, 9'd0, 8'hA7});
        tick();
        ioctl_addr = 25'd0;
        check("ul_addr_phase", W'({busy, nv_addr}), W'({1'b1, 9'h1FF}));
        tick();
        ioctl_rd = 1'b0;
        tick();
        read_byte(25'd600, 8'hFF);
        read_byte(25'd5, 8'h5F);
        read_byte(25'h100, 8'h5A);
        ioctl_upload = 1'b0;
        tick();
        tick();
        check("dirty_ul_clear", W'(nv_dirty), W'(0));

        // Wipe from IDLE.
        c = cyc;
        wipe = 1'b1;
        for (int k = 0; k < 512; k++) wr_q.push_back({c + 32'd1 + 32'(k), 9'(k), 8'hFF});
        tick();
        wipe = 1'b0;
        n = 0;
        for (int i = 0; i < 512; i++) begin
            if (busy) n++;
            tick();
        end
        check("wipe_busy_cycles", W'(n), W'(512));
        check("wipe_end", W'({busy, nv_dirty}), W'(2'b01));

        // Plain download enter/exit clears dirty; wipe during DL waits; set beats clear.
        ioctl_download = 1'b1;
        tick();
        tick();
        ioctl_download = 1'b0;
        tick();
        tick();
        check("dirty_dl_clear2", W'(nv_dirty), W'(0));
        ioctl_download = 1'b1;
        tick();
        wipe = 1'b1;
        tick();
        wipe = 1'b0;
        tick();
        check("dl_busy_wipe_held", W'({busy, nv_we}), W'(2'b10));
        ioctl_download = 1'b0;
        cpu_nv_we = 1'b1;
        c = cyc;
        for (int k = 0; k < 512; k++) wr_q.push_back({c + 32'd2 + 32'(k), 9'(k), 8'hFF});
        tick();
        cpu_nv_we = 1'b0;
        check("dirty_set_wins", W'(nv_dirty), W'(1));
        repeat (520) tick();
        check("pending_wipe_done", W'(busy), W'(0));

        // Unselected index traffic must not touch the RAM or leave IDLE.
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        tick();
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd5;
        ioctl_dout = 8'h11;
        tick();
        tick();
        ioctl_wr = 1'b0;
        check("unsel_dl_idle", W'(busy), W'(0));
        ioctl_download = 1'b0;
        ioctl_upload = 1'b1;
        ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        tick();
        check("unsel_ul_idle", W'(busy), W'(0));
        check("unsel_ram", W'(mem[5]), W'(8'hFF));
        ioctl_upload = 1'b0;
        ioctl_index = NV;

        // Reset at wipe address 100 with a second wipe pending.
        c = cyc;
        wipe = 1'b1;
        for (int k = 0; k <= 100; k++) wr_q.push_back({c + 32'd1 + 32'(k), 9'(k), 8'hFF});
        tick();
        wipe = 1'b0;
        repeat (49) tick();
        wipe = 1'b1;
        tick();
        wipe = 1'b0;
        repeat (50) tick();
        check("wipe_addr_100", W'(nv_addr), W'(100));
        reset = 1'b1;
        tick();
        check("reset_mid_wipe", W'({busy, nv_we, nv_dirty, nv_addr}), W'(0));
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy) n++;
        end
        check("no_pending_after_reset", W'(n), W'(0));

        // Autosave: one CPU write, then a single save request after the quiet time.
        c = cyc;
        cpu_nv_we = 1'b1;
        tick();
        cpu_nv_we = 1'b0;
        n = 0;
        at = '0;
        for (int i = 0; i < 60; i++) begin
            if (save_req) begin
                n++;
                at = cyc;
            end
            tick();
        end
`ifdef NVRAM_AUTOSAVE_EN
        check("save_req_count", W'(n), W'(1));
        check("save_req_timing", W'(at >= c + 32'd15 && at <= c + 32'd18), W'(1));
`else
        check("save_req_tied", W'(n), W'(0));
`endif

        n = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check("wr_queue_drained", W'(wr_q.size()), W'(0));
        check("rd_queue_drained", W'(rd_q.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
